// File: rtl/nbit_seq_divider.sv
// rtl/nbit_seq_divider.sv - iterative restoring divider, one trial subtract per clock, valid/ready both sides
// Optional signed operation via DIV_SIGNED_EN.
module nbit_seq_divider #(
    parameter int BITWIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] dividend,
    input  logic [BITWIDTH-1:0] divisor,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] quotient,
    output logic [BITWIDTH-1:0] remainder,
    output logic                div_by_zero
);
    localparam int CW = $clog2(BITWIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    // dvd shifts left each step; quotient bits enter at its LSB and fill it by the end
    logic [BITWIDTH-1:0] dvd;
    logic [BITWIDTH-1:0] dsr;
    logic [BITWIDTH-1:0] p;
    logic [CW-1:0]       cnt;
    logic                zflag;

    logic                accept;
    logic                divisor_zero;
    logic [BITWIDTH:0]   p_shift;
    logic [BITWIDTH:0]   diff;
    logic                ge;
    logic [BITWIDTH-1:0] p_next;
    logic [BITWIDTH-1:0] q_next;
    logic [BITWIDTH-1:0] q_final;
    logic [BITWIDTH-1:0] r_final;
    logic [BITWIDTH-1:0] dvd_load;
    logic [BITWIDTH-1:0] dsr_load;

    assign accept       = in_valid & in_ready;
    assign divisor_zero = (divisor == '0);

    // Partial remainder stays below the divisor, so the BITWIDTH+1-bit difference never overflows
    assign p_shift = {p, dvd[BITWIDTH-1]};
    assign diff    = p_shift - {1'b0, dsr};
    assign ge      = ~diff[BITWIDTH];
    assign p_next  = ge ? diff[BITWIDTH-1:0] : p_shift[BITWIDTH-1:0];
    assign q_next  = {dvd[BITWIDTH-2:0], ge};

`ifdef DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // Raw dividend kept for divide-by-zero so the remainder reports it unchanged
    assign dvd_load = (dividend[BITWIDTH-1] && !divisor_zero) ? (~dividend + 1'b1) : dividend;
    assign dsr_load = divisor[BITWIDTH-1] ? (~divisor + 1'b1) : divisor;
    assign q_final  = neg_q ? (~q_next + 1'b1) : q_next;
    assign r_final  = neg_r ? (~p_next + 1'b1) : p_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (accept) begin
            neg_q <= dividend[BITWIDTH-1] ^ divisor[BITWIDTH-1];
            neg_r <= dividend[BITWIDTH-1];
        end
    end
`else
    assign dvd_load = dividend;
    assign dsr_load = divisor;
    assign q_final  = q_next;
    assign r_final  = p_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = CALC;
            CALC:    if (zflag || cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd         <= '0;
            dsr         <= '0;
            p           <= '0;
            cnt         <= '0;
            zflag       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            dvd         <= dvd_load;
            dsr         <= dsr_load;
            p           <= '0;
            cnt         <= CW'(BITWIDTH - 1);
            zflag       <= divisor_zero;
            div_by_zero <= 1'b0;
        end else if (state == CALC) begin
            if (zflag) begin
                quotient    <= '1;
                remainder   <= dvd;
                div_by_zero <= 1'b1;
            end else begin
                dvd <= q_next;
                p   <= p_next;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    quotient  <= q_final;
                    remainder <= r_final;
                end
            end
        end
    end

endmodule

// File: tb/tb_nbit_seq_divider.sv
// tb/tb_nbit_seq_divider.sv - scoreboard bench for nbit_seq_divider (BITWIDTH=8)
module tb_nbit_seq_divider;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic [7:0] lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    nbit_seq_divider #(.BITWIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sbv, qi, ri;
        if (b == 8'd0) begin
            e.q = 8'hFF; e.r = a; e.dbz = 1'b1; e.lat = 8'd1;
        end else begin
`ifdef DIV_SIGNED_EN
            sa  = int'($signed(a));
            sbv = int'($signed(b));
`else
            sa  = int'(a);
            sbv = int'(b);
`endif
            qi = sa / sbv;
            ri = sa % sbv;
            e.q = qi[7:0]; e.r = ri[7:0]; e.dbz = 1'b0; e.lat = 8'd8;
        end
        return e;
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("in_ready_idle", in_ready, 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        check("in_ready_busy", in_ready, 0);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("latency", cyc, e.lat);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_q", quotient, e.q);
            check("stall_r", remainder, e.r);
            @(posedge clk); #1;
        end
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", div_by_zero, e.dbz);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_cleared", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("q_held", quotient, e.q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 8'd0;
        divisor   = 8'd0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'd200, 8'd7, 0);
        run_op(8'd255, 8'd1, 0);
        run_op(8'd5, 8'd9, 0);
        run_op(8'd37, 8'd0, 0);
        run_op(8'd100, 8'd3, 5);

        // Abort mid-calculation: reset asserted during the 4th CALC cycle
        dividend = 8'd200;
        divisor  = 8'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd9, 8'd2, 0);

`ifdef DIV_SIGNED_EN
        run_op(8'hF9, 8'd2, 0);
        run_op(8'h80, 8'hFF, 0);
        run_op(8'h80, 8'h00, 0);
`endif

        for (int k = 0; k < 6; k++) begin
            run_op(8'($urandom), 8'($urandom_range(1, 255)), k % 2);
        end
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
